// File: rtl/hb3_motor_ctrl.sv
// hb3_motor_ctrl: PWM generation, dead-time direction sequencing and hall-sensor
// speed measurement for the PmodHB3 H-bridge.
// Optional build macro HB3_SOFTSTART_EN: duty ramps by +/-1 per PWM period
// instead of jumping to the requested value.
module hb3_motor_ctrl #(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned DEADTIME_CYC = 1000,
   parameter int unsigned GATE_CYC     = 100000000,
   parameter int unsigned SPEED_BITS   = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cfg_enable,
   input  logic                  cfg_dir,
   input  logic [PWM_BITS-1:0]   cfg_duty,
   input  logic [15:0]           cfg_prescale,
   input  logic                  hb_sa,
   output logic                  hb_en,
   output logic                  hb_dir,
   output logic                  dir_busy,
   output logic [SPEED_BITS-1:0] speed_count,
   output logic                  speed_valid
);

   localparam int unsigned PRESC_W = 16;
   localparam int unsigned DEAD_W  = $clog2(DEADTIME_CYC + 1);
   localparam int unsigned GATE_W  = $clog2(GATE_CYC + 1);

   localparam logic [PWM_BITS-1:0] PWM_MAX   = PWM_BITS'((2 ** PWM_BITS) - 2);
   localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEADTIME_CYC - 1);
   localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2,
      S_SWAP = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
   logic                hb_dir_q, hb_dir_d;
   logic                dir_busy_q, dir_busy_d;
   logic                run_entry;

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [PRESC_W-1:0]  presc_lim_q, presc_lim_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                hb_en_q, hb_en_d;
   logic                pwm_tick, pwm_wrap;

   logic                sa_meta_q, sa_sync_q, sa_prev_q;
   logic                sa_edge, edge_sat;
   logic [GATE_W-1:0]   gate_q, gate_d;
   logic [SPEED_BITS-1:0] edge_cnt_q, edge_cnt_d;
   logic [SPEED_BITS-1:0] speed_count_q, speed_count_d;
   logic                speed_valid_q, speed_valid_d;

   // Direction sequencing FSM: next state, dead-time counter and direction latch.
   always_comb begin
      state_d    = state_q;
      dead_cnt_d = '0;
      hb_dir_d   = hb_dir_q;
      run_entry  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_dir != hb_dir_q) begin
               state_d = S_DEAD;
            end else if (cfg_enable) begin
               state_d   = S_RUN;
               run_entry = 1'b1;
            end
         end
         S_RUN: begin
            if (!cfg_enable) begin
               state_d = S_IDLE;
            end else if (cfg_dir != hb_dir_q) begin
               state_d = S_DEAD;
            end
         end
         S_DEAD: begin
            if (dead_cnt_q == DEAD_LAST) begin
               state_d = S_SWAP;
            end else begin
               dead_cnt_d = dead_cnt_q + DEAD_W'(1);
            end
         end
         S_SWAP: begin
            hb_dir_d = cfg_dir;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      dir_busy_d = (state_d == S_DEAD) || (state_d == S_SWAP);
   end

   // Prescaler, PWM counter and duty latch; hb_en is derived from next-state values
   // so the registered output lines up with the registered FSM state.
   always_comb begin
      presc_d     = presc_q;
      presc_lim_d = presc_lim_q;
      pwm_d       = pwm_q;
      duty_d      = duty_q;
      pwm_tick    = 1'b0;
      pwm_wrap    = 1'b0;
      if (run_entry) begin
         presc_d     = '0;
         presc_lim_d = cfg_prescale;
         pwm_d       = '0;
`ifdef HB3_SOFTSTART_EN
         duty_d      = '0;
`else
         duty_d      = cfg_duty;
`endif
      end else if (state_q == S_RUN) begin
         if (presc_q == presc_lim_q) begin
            presc_d     = '0;
            presc_lim_d = cfg_prescale;
            pwm_tick    = 1'b1;
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
         if (pwm_tick) begin
            if (pwm_q == PWM_MAX) begin
               pwm_d    = '0;
               pwm_wrap = 1'b1;
            end else begin
               pwm_d = pwm_q + PWM_BITS'(1);
            end
         end
         if (pwm_wrap) begin
`ifdef HB3_SOFTSTART_EN
            if (duty_q < cfg_duty) begin
               duty_d = duty_q + PWM_BITS'(1);
            end else if (duty_q > cfg_duty) begin
               duty_d = duty_q - PWM_BITS'(1);
            end
`else
            duty_d = cfg_duty;
`endif
         end
      end
      hb_en_d = (state_d == S_RUN) && (pwm_d < duty_d);
   end

   // Speed window: count synchronized SA rising edges, publish on gate wrap.
   always_comb begin
      sa_edge       = sa_sync_q & ~sa_prev_q;
      edge_sat      = &edge_cnt_q;
      speed_count_d = speed_count_q;
      speed_valid_d = 1'b0;
      if (sa_edge && !edge_sat) begin
         edge_cnt_d = edge_cnt_q + SPEED_BITS'(1);
      end else begin
         edge_cnt_d = edge_cnt_q;
      end
      if (gate_q == GATE_LAST) begin
         gate_d        = '0;
         speed_count_d = edge_cnt_d;
         edge_cnt_d    = '0;
         speed_valid_d = 1'b1;
      end else begin
         gate_d = gate_q + GATE_W'(1);
      end
   end

   // FSM and direction registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= S_IDLE;
         dead_cnt_q <= '0;
         hb_dir_q   <= 1'b0;
         dir_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dead_cnt_q <= dead_cnt_d;
         hb_dir_q   <= hb_dir_d;
         dir_busy_q <= dir_busy_d;
      end
   end

   // PWM registers; hb_en clears asynchronously with reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         presc_q     <= '0;
         presc_lim_q <= '0;
         pwm_q       <= '0;
         duty_q      <= '0;
         hb_en_q     <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         presc_lim_q <= presc_lim_d;
         pwm_q       <= pwm_d;
         duty_q      <= duty_d;
         hb_en_q     <= hb_en_d;
      end
   end

   // Two-flop synchronizer for hall input plus edge-detect history.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         sa_meta_q <= 1'b0;
         sa_sync_q <= 1'b0;
         sa_prev_q <= 1'b0;
      end else begin
         sa_meta_q <= hb_sa;
         sa_sync_q <= sa_meta_q;
         sa_prev_q <= sa_sync_q;
      end
   end

   // Speed measurement registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         gate_q        <= '0;
         edge_cnt_q    <= '0;
         speed_count_q <= '0;
         speed_valid_q <= 1'b0;
      end else begin
         gate_q        <= gate_d;
         edge_cnt_q    <= edge_cnt_d;
         speed_count_q <= speed_count_d;
         speed_valid_q <= speed_valid_d;
      end
   end

   assign hb_en       = hb_en_q;
   assign hb_dir      = hb_dir_q;
   assign dir_busy    = dir_busy_q;
   assign speed_count = speed_count_q;
   assign speed_valid = speed_valid_q;

endmodule

// File: tb/tb_hb3_motor_ctrl.sv
// Directed bench for hb3_motor_ctrl: PWM duty table, mid-period duty change,
// direction reversal with dead time, reversal revert, reset, disable priority
// and hall-sensor speed windows.
module tb_hb3_motor_ctrl;

   localparam int unsigned DEAD = 1000;
   localparam int unsigned GATE = 1000;

   logic        ACLK;
   logic        ARESETN;
   logic        cfg_enable;
   logic        cfg_dir;
   logic [7:0]  cfg_duty;
   logic [15:0] cfg_prescale;
   logic        hb_sa;
   logic        hb_en;
   logic        hb_dir;
   logic        dir_busy;
   logic [31:0] speed_count;
   logic        speed_valid;

   int tests = 0;
   int fails = 0;

   hb3_motor_ctrl #(
      .PWM_BITS    (8),
      .DEADTIME_CYC(DEAD),
      .GATE_CYC    (GATE),
      .SPEED_BITS  (32)
   ) dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .cfg_enable  (cfg_enable),
      .cfg_dir     (cfg_dir),
      .cfg_duty    (cfg_duty),
      .cfg_prescale(cfg_prescale),
      .hb_sa       (hb_sa),
      .hb_en       (hb_en),
      .hb_dir      (hb_dir),
      .dir_busy    (dir_busy),
      .speed_count (speed_count),
      .speed_valid (speed_valid)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Hall sensor: 40-clock period square wave, phase offset from the clock.
   initial begin
      hb_sa = 1'b0;
      #3;
      forever #200 hb_sa = ~hb_sa;
   end

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic count_high(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         tick(1);
         if (hb_en) cnt++;
      end
   endtask

   // Dead-time invariant: hb_dir may only change after a long enough low run of hb_en.
   logic prev_dir;
   int   low_run;
   always @(negedge ACLK) begin
      if (!ARESETN) begin
         prev_dir = hb_dir;
         low_run  = 0;
      end else begin
         if (hb_dir != prev_dir) check_rng("deadtime_invariant", low_run, DEAD, 64'd1 << 40);
         prev_dir = hb_dir;
         low_run  = hb_en ? 0 : low_run + 1;
      end
   end

   // Speed window monitor: pulse spacing and count per window.
   int cyc_since = 0;
   int win_seen  = 0;
   bit first_win = 1'b1;
   always @(negedge ACLK) begin
      if (!ARESETN) begin
         cyc_since = 0;
         first_win = 1'b1;
      end else begin
         cyc_since++;
         if (speed_valid) begin
            if (!first_win) begin
               check("speed_valid_period", cyc_since, GATE);
               check_rng("speed_count", speed_count, 24, 26);
               win_seen++;
            end
            first_win = 1'b0;
            cyc_since = 0;
         end
      end
   end

   typedef struct {
      logic [7:0]  duty;
      logic [15:0] presc;
      int          win;
      int          exp_hi;
   } vec_t;

   vec_t vecs[9];
   int   cnt;
   int   flip;
   bit   en_early;
   bit   found;
   bit   prev_en;

   initial begin
      vecs[0] = '{8'd64,  16'd0, 255,  64};
      vecs[1] = '{8'd64,  16'd0, 510,  128};
      vecs[2] = '{8'd0,   16'd0, 1000, 0};
      vecs[3] = '{8'd255, 16'd0, 1000, 1000};
      vecs[4] = '{8'd128, 16'd1, 510,  256};
      vecs[5] = '{8'd100, 16'd2, 765,  300};
      vecs[6] = '{8'd10,  16'd3, 1020, 40};
      vecs[7] = '{8'd1,   16'd0, 255,  1};
      vecs[8] = '{8'd254, 16'd0, 255,  254};

      ARESETN      = 1'b0;
      cfg_enable   = 1'b0;
      cfg_dir      = 1'b0;
      cfg_duty     = 8'd0;
      cfg_prescale = 16'd0;
      tick(3);
      check("rst_hb_en", hb_en, 0);
      check("rst_hb_dir", hb_dir, 0);
      check("rst_dir_busy", dir_busy, 0);
      check("rst_speed_count", speed_count, 0);
      check("rst_speed_valid", speed_valid, 0);
      ARESETN = 1'b1;
      tick(2);
      check("idle_hb_en", hb_en, 0);
      check("idle_dir_busy", dir_busy, 0);

      // Duty / prescale table.
      for (int i = 0; i < 9; i++) begin
         cfg_enable = 1'b0;
         tick(3);
         cfg_duty     = vecs[i].duty;
         cfg_prescale = vecs[i].presc;
         cfg_enable   = 1'b1;
         tick(5);
         count_high(vecs[i].win, cnt);
         check($sformatf("vec%0d_high_count", i), cnt, vecs[i].exp_hi);
         check($sformatf("vec%0d_hb_dir", i), hb_dir, 0);
      end

      // Duty 64 -> 200 changed right after the falling edge applies only after the wrap.
      cfg_enable = 1'b0;
      tick(3);
      cfg_duty     = 8'd64;
      cfg_prescale = 16'd0;
      cfg_enable   = 1'b1;
      tick(3);
      found   = 1'b0;
      prev_en = hb_en;
      for (int k = 0; k < 600; k++) begin
         tick(1);
         if (prev_en && !hb_en) begin
            found = 1'b1;
            break;
         end
         prev_en = hb_en;
      end
      check("midper_fall_found", found, 1);
      cfg_duty = 8'd200;
      count_high(190, cnt);
      check("midper_rest_low", cnt, 0);
      count_high(200, cnt);
      check("midper_new_high", cnt, 200);
      count_high(55, cnt);
      check("midper_new_low", cnt, 0);

      // Reversal at full duty.
      cfg_enable = 1'b0;
      tick(3);
      cfg_duty   = 8'd255;
      cfg_enable = 1'b1;
      tick(5);
      check("rev_pre_hb_en", hb_en, 1);
      cfg_dir = 1'b1;
      tick(1);
      check("rev_hb_en_low", hb_en, 0);
      check("rev_dir_busy", dir_busy, 1);
      check("rev_hb_dir_old", hb_dir, 0);
      flip     = -1;
      en_early = 1'b0;
      for (int k = 1; k <= 1100; k++) begin
         tick(1);
         if (flip < 0 && hb_dir) flip = k;
         else if (flip < 0 && hb_en) en_early = 1'b1;
         if (flip > 0 && k == flip + 1) break;
      end
      check("rev_flip_delay", flip, DEAD + 1);
      check("rev_en_during_dead", en_early, 0);
      check("rev_resume_hb_en", hb_en, 1);
      check("rev_resume_busy", dir_busy, 0);

      // Request reverts to the old direction during DEAD.
      cfg_dir = 1'b0;
      tick(1);
      check("revert_busy", dir_busy, 1);
      tick(100);
      cfg_dir = 1'b1;
      tick(1050);
      check("revert_hb_dir", hb_dir, 1);
      check("revert_busy_done", dir_busy, 0);
      check("revert_back_in_run", hb_en, 1);

      // Asynchronous reset mid-RUN with hb_en high and hb_dir=1.
      ARESETN = 1'b0;
      cfg_dir = 1'b0;
      #1;
      check("arst_hb_en", hb_en, 0);
      check("arst_hb_dir", hb_dir, 0);
      check("arst_dir_busy", dir_busy, 0);
      check("arst_speed_count", speed_count, 0);
      check("arst_speed_valid", speed_valid, 0);
      tick(2);
      cfg_duty   = 8'd64;
      cfg_enable = 1'b1;
      ARESETN    = 1'b1;
      tick(5);
      count_high(255, cnt);
      check("post_rst_high_count", cnt, 64);

      // Disable and reversal together: disable wins, then dead time still runs.
      cfg_duty = 8'd255;
      tick(300);
      check("prio_pre_hb_en", hb_en, 1);
      cfg_enable = 1'b0;
      cfg_dir    = 1'b1;
      tick(1);
      check("prio_hb_en", hb_en, 0);
      check("prio_idle_busy", dir_busy, 0);
      tick(1);
      check("prio_dead_busy", dir_busy, 1);
      tick(1005);
      check("prio_hb_dir", hb_dir, 1);
      check("prio_end_hb_en", hb_en, 0);
      check("prio_end_busy", dir_busy, 0);

      check_rng("speed_windows_seen", win_seen, 5, 1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
